rtc_display_latch: RTL and testbench

RTC_DISPLAY_LATCH -- requirements
Module: rtc_display_latch

---
 rtl/rtc_display_latch.sv | 126 ++++++++++++
 tb/tb_rtc_display_latch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rtc_display_latch.sv
// rtl/rtc_display_latch.sv - frame-synchronous RTC display latch with shadow/committed banks and alarm blink
module rtc_display_latch #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_EN,
  input  logic [3:0] WR_ADDR,
  input  logic [7:0] WR_DATA,
  input  logic       VS,
  input  logic       ALARMA_IN,
  output logic [7:0] DIA_T,
  output logic [7:0] MES_T,
  output logic [7:0] ANO_T,
  output logic [7:0] HORA_T,
  output logic [7:0] MINUTO_T,
  output logic [7:0] SEGUNDO_T,
  output logic [7:0] HORAT_T,
  output logic [7:0] MINUTOT_T,
  output logic [7:0] SEGUNDOT_T,
  output logic       ALARMA,
  output logic       PEND,
  output logic [7:0] ERR_CNT
);

  localparam logic [5:0] FC_LAST = 6'(BLINK_FRAMES - 1);

  logic [7:0] shadow_q [9];
  logic [7:0] shadow_d [9];
  logic [7:0] commit_q [9];
  logic [7:0] commit_d [9];
  logic       dirty_q, dirty_d;
  logic       vs_q, vs_d;
  logic [7:0] err_q, err_d;
  logic [5:0] fc_q, fc_d;
  logic       ph_q, ph_d;
  logic       alarma_q, alarma_d;

  logic       wr_ok;
  logic       wr_bad;
  logic       frame_edge;

  // A write is accepted only for a real register and a packed BCD byte.
  assign wr_ok  = WR_EN && (WR_ADDR <= 4'd8) && (WR_DATA[7:4] <= 4'd9) && (WR_DATA[3:0] <= 4'd9);
  assign wr_bad = WR_EN && !wr_ok;

  // VS falling edge seen against the registered copy; acts on the next clock.
  assign frame_edge = vs_q && !VS;

  // Shadow/commit bank: commit copies the pre-write shadow, a coincident write keeps dirty set.
  always_comb begin
    shadow_d = shadow_q;
    commit_d = commit_q;
    dirty_d  = dirty_q;
    err_d    = err_q;
    if (frame_edge && dirty_q) begin
      commit_d = shadow_q;
      dirty_d  = 1'b0;
    end
    if (wr_ok) begin
      shadow_d[WR_ADDR] = WR_DATA;
      dirty_d           = 1'b1;
    end
    if (wr_bad && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // Alarm blink: frame counter and phase advance only while the alarm is active.
  always_comb begin
    fc_d     = fc_q;
    ph_d     = ph_q;
    vs_d     = VS;
    alarma_d = ALARMA_IN & ph_q;
    if (!ALARMA_IN) begin
      fc_d = 6'd0;
      ph_d = 1'b1;
    end else if (frame_edge) begin
      if (fc_q == FC_LAST) begin
        fc_d = 6'd0;
        ph_d = ~ph_q;
      end else begin
        fc_d = fc_q + 6'd1;
      end
    end
  end

  // State registers; reset clears both banks so a pre-reset write can never commit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 9; i++) begin
        shadow_q[i] <= 8'h00;
        commit_q[i] <= 8'h00;
      end
      dirty_q  <= 1'b0;
      vs_q     <= 1'b1;
      err_q    <= 8'h00;
      fc_q     <= 6'd0;
      ph_q     <= 1'b1;
      alarma_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      commit_q <= commit_d;
      dirty_q  <= dirty_d;
      vs_q     <= vs_d;
      err_q    <= err_d;
      fc_q     <= fc_d;
      ph_q     <= ph_d;
      alarma_q <= alarma_d;
    end
  end

  assign DIA_T      = commit_q[0];
  assign MES_T      = commit_q[1];
  assign ANO_T      = commit_q[2];
  assign HORA_T     = commit_q[3];
  assign MINUTO_T   = commit_q[4];
  assign SEGUNDO_T  = commit_q[5];
  assign HORAT_T    = commit_q[6];
  assign MINUTOT_T  = commit_q[7];
  assign SEGUNDOT_T = commit_q[8];
  assign ALARMA     = alarma_q;
  assign PEND       = dirty_q;
  assign ERR_CNT    = err_q;

endmodule

// File: tb/tb_rtc_display_latch.sv
// tb/tb_rtc_display_latch.sv - directed self-checking bench for rtc_display_latch
module tb_rtc_display_latch;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       WR_EN = 1'b0;
  logic [3:0] WR_ADDR = 4'd0;
  logic [7:0] WR_DATA = 8'h00;
  logic       VS = 1'b1;
  logic       ALARMA_IN = 1'b0;
  logic [7:0] DIA_T, MES_T, ANO_T, HORA_T, MINUTO_T, SEGUNDO_T, HORAT_T, MINUTOT_T, SEGUNDOT_T;
  logic       ALARMA, PEND;
  logic [7:0] ERR_CNT;

  rtc_display_latch #(.BLINK_FRAMES(30)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .VS(VS), .ALARMA_IN(ALARMA_IN),
    .DIA_T(DIA_T), .MES_T(MES_T), .ANO_T(ANO_T), .HORA_T(HORA_T), .MINUTO_T(MINUTO_T),
    .SEGUNDO_T(SEGUNDO_T), .HORAT_T(HORAT_T), .MINUTOT_T(MINUTOT_T), .SEGUNDOT_T(SEGUNDOT_T),
    .ALARMA(ALARMA), .PEND(PEND), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [7:0] obs);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic check_all_t(input string tag, input logic [7:0] v);
    push_exp({tag, "_dia"}, v);      check(DIA_T);
    push_exp({tag, "_mes"}, v);      check(MES_T);
    push_exp({tag, "_ano"}, v);      check(ANO_T);
    push_exp({tag, "_hora"}, v);     check(HORA_T);
    push_exp({tag, "_minuto"}, v);   check(MINUTO_T);
    push_exp({tag, "_segundo"}, v);  check(SEGUNDO_T);
    push_exp({tag, "_horat"}, v);    check(HORAT_T);
    push_exp({tag, "_minutot"}, v);  check(MINUTOT_T);
    push_exp({tag, "_segundot"}, v); check(SEGUNDOT_T);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    WR_EN   = 1'b1;
    WR_ADDR = a;
    WR_DATA = d;
    tick();
    WR_EN   = 1'b0;
  endtask

  task automatic frame();
    VS = 1'b0;
    tick();
    VS = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    #2;
    check_all_t("rst", 8'h00);
    push_exp("rst_pend", 8'h00);   check({7'd0, PEND});
    push_exp("rst_alarma", 8'h00); check({7'd0, ALARMA});
    push_exp("rst_err", 8'h00);    check(ERR_CNT);
    tick();
    RST = 1'b1;
    tick();

    // Buffered writes commit together one clock after VS falls
    wr(4'd3, 8'h23);
    wr(4'd4, 8'h59);
    tick();
    push_exp("pre_hora", 8'h00);   check(HORA_T);
    push_exp("pre_minuto", 8'h00); check(MINUTO_T);
    push_exp("pre_pend", 8'h01);   check({7'd0, PEND});
    VS = 1'b0;
    #1;
    push_exp("fall_hora_hold", 8'h00); check(HORA_T);
    tick();
    push_exp("cm_hora", 8'h23);   check(HORA_T);
    push_exp("cm_minuto", 8'h59); check(MINUTO_T);
    push_exp("cm_pend", 8'h00);   check({7'd0, PEND});
    VS = 1'b1;
    tick();

    // Rejected writes and ERR_CNT saturation
    wr(4'd0, 8'h3A);
    wr(4'd12, 8'h11);
    push_exp("err_two", 8'h02);  check(ERR_CNT);
    push_exp("err_pend", 8'h00); check({7'd0, PEND});
    frame();
    push_exp("err_dia", 8'h00);  check(DIA_T);
    push_exp("err_hora", 8'h23); check(HORA_T);
    WR_EN   = 1'b1;
    WR_ADDR = 4'd9;
    WR_DATA = 8'h00;
    for (int i = 0; i < 256; i++) tick();
    WR_EN = 1'b0;
    push_exp("err_sat", 8'hFF); check(ERR_CNT);

    // Write coinciding with commit: old value commits, new one stays pending
    wr(4'd5, 8'h41);
    VS      = 1'b0;
    WR_EN   = 1'b1;
    WR_ADDR = 4'd5;
    WR_DATA = 8'h42;
    tick();
    WR_EN = 1'b0;
    push_exp("coin_seg", 8'h41);  check(SEGUNDO_T);
    push_exp("coin_pend", 8'h01); check({7'd0, PEND});
    VS = 1'b1;
    tick();
    frame();
    push_exp("coin_seg2", 8'h42);  check(SEGUNDO_T);
    push_exp("coin_pend2", 8'h00); check({7'd0, PEND});

    // Alarm blink: on for 30 frame edges, off for 30
    ALARMA_IN = 1'b1;
    tick();
    push_exp("al_on", 8'h01); check({7'd0, ALARMA});
    for (int i = 0; i < 29; i++) frame();
    push_exp("al_29", 8'h01); check({7'd0, ALARMA});
    frame();
    push_exp("al_30", 8'h00); check({7'd0, ALARMA});
    for (int i = 0; i < 29; i++) frame();
    push_exp("al_59", 8'h00); check({7'd0, ALARMA});
    frame();
    push_exp("al_60", 8'h01); check({7'd0, ALARMA});
    for (int i = 0; i < 30; i++) frame();
    ALARMA_IN = 1'b0;
    tick();
    push_exp("al_drop", 8'h00); check({7'd0, ALARMA});
    ALARMA_IN = 1'b1;
    tick();
    push_exp("al_reraise", 8'h01); check({7'd0, ALARMA});

    // Reset mid-frame discards pending write
    wr(4'd8, 8'h07);
    push_exp("rs_pend_pre", 8'h01); check({7'd0, PEND});
    #2;
    RST = 1'b0;
    #1;
    check_all_t("rs_async", 8'h00);
    push_exp("rs_pend", 8'h00);   check({7'd0, PEND});
    push_exp("rs_alarma", 8'h00); check({7'd0, ALARMA});
    push_exp("rs_err", 8'h00);    check(ERR_CNT);
    ALARMA_IN = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    frame();
    push_exp("rs_segt", 8'h00);    check(SEGUNDOT_T);
    push_exp("rs_pend_post", 8'h00); check({7'd0, PEND});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
